// File: rtl/fp_align_shifter.sv
// FP32 pre-add alignment: orders operands by magnitude, then right-shifts the
// smaller significand to the larger exponent with guard/round/sticky bits.
module fp_align_shifter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  exp_large,
   output logic [26:0] sig_large,
   output logic [26:0] sig_small,
   output logic        sign_large,
   output logic        eff_sub,
   output logic        swap
);

   logic [2:1]  r_vld_pipe;
   logic        w_en;

   logic [7:0]  w_exp_a, w_exp_b, w_exp_l, w_exp_s, w_diff;
   logic [23:0] w_sig_a, w_sig_b;
   logic        w_swap;
   logic [4:0]  w_sh;

   logic [23:0] r1_sig_l, r1_sig_s;
   logic [7:0]  r1_exp_l;
   logic [4:0]  r1_sh;
   logic        r1_sign_l, r1_eff_sub, r1_swap;

   logic [26:0] w_ext, w_mask, w_shifted, w_sig_small;
   logic        w_sticky;

   logic [7:0]  r2_exp_l;
   logic [26:0] r2_sig_l, r2_sig_s;
   logic        r2_sign_l, r2_eff_sub, r2_swap;

   assign w_en     = ~r_vld_pipe[2] | out_ready;
   assign in_ready = w_en;

   // Subnormals (exponent 0) behave as exponent 1 with hidden bit clear
   assign w_exp_a = (op_a[30:23] == 8'd0) ? 8'd1 : op_a[30:23];
   assign w_exp_b = (op_b[30:23] == 8'd0) ? 8'd1 : op_b[30:23];
   assign w_sig_a = {|op_a[30:23], op_a[22:0]};
   assign w_sig_b = {|op_b[30:23], op_b[22:0]};

   assign w_swap  = (w_exp_b > w_exp_a) || ((w_exp_b == w_exp_a) && (w_sig_b > w_sig_a));
   assign w_exp_l = w_swap ? w_exp_b : w_exp_a;
   assign w_exp_s = w_swap ? w_exp_a : w_exp_b;
   assign w_diff  = w_exp_l - w_exp_s;
   assign w_sh    = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];

   // Anything at or beyond 27 positions collapses entirely into sticky
   assign w_ext       = {r1_sig_s, 3'b000};
   assign w_mask      = 27'((28'd1 << r1_sh) - 28'd1);
   assign w_shifted   = w_ext >> r1_sh;
   assign w_sticky    = |(w_ext & w_mask);
   assign w_sig_small = {w_shifted[26:1], w_shifted[0] | w_sticky};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
      end else if (flush) begin
         r_vld_pipe <= '0;
      end else if (w_en) begin
         r_vld_pipe <= {r_vld_pipe[1], in_valid};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_sig_l   <= '0;
         r1_sig_s   <= '0;
         r1_exp_l   <= '0;
         r1_sh      <= '0;
         r1_sign_l  <= 1'b0;
         r1_eff_sub <= 1'b0;
         r1_swap    <= 1'b0;
         r2_exp_l   <= '0;
         r2_sig_l   <= '0;
         r2_sig_s   <= '0;
         r2_sign_l  <= 1'b0;
         r2_eff_sub <= 1'b0;
         r2_swap    <= 1'b0;
      end else if (w_en) begin
         r1_sig_l   <= w_swap ? w_sig_b : w_sig_a;
         r1_sig_s   <= w_swap ? w_sig_a : w_sig_b;
         r1_exp_l   <= w_exp_l;
         r1_sh      <= w_sh;
         r1_sign_l  <= w_swap ? (op_b[31] ^ sub) : op_a[31];
         r1_eff_sub <= op_a[31] ^ op_b[31] ^ sub;
         r1_swap    <= w_swap;
         r2_exp_l   <= r1_exp_l;
         r2_sig_l   <= {r1_sig_l, 3'b000};
         r2_sig_s   <= w_sig_small;
         r2_sign_l  <= r1_sign_l;
         r2_eff_sub <= r1_eff_sub;
         r2_swap    <= r1_swap;
      end
   end

   assign out_valid  = r_vld_pipe[2];
   assign exp_large  = r2_exp_l;
   assign sig_large  = r2_sig_l;
   assign sig_small  = r2_sig_s;
   assign sign_large = r2_sign_l;
   assign eff_sub    = r2_eff_sub;
   assign swap       = r2_swap;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Scoreboard bench for fp_align_shifter: directed vectors with literal
// expectations plus randomized traffic checked against an arithmetic model.
module tb_fp_align_shifter;

   typedef struct packed {
      logic [7:0]  exp_large;
      logic [26:0] sig_large;
      logic [26:0] sig_small;
      logic        sign_large;
      logic        eff_sub;
      logic        swap;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  exp_large;
   logic [26:0] sig_large;
   logic [26:0] sig_small;
   logic        sign_large;
   logic        eff_sub;
   logic        swap;

   int   checks = 0;
   int   errors = 0;
   int   n_acc = 0;
   bit   rand_bp = 1'b0;
   res_t sb[$];

   fp_align_shifter dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .exp_large(exp_large), .sig_large(sig_large), .sig_small(sig_small),
      .sign_large(sign_large), .eff_sub(eff_sub), .swap(swap)
   );

   always #5 clk = ~clk;

   function automatic res_t cur_out();
      res_t r;
      r = '{exp_large, sig_large, sig_small, sign_large, eff_sub, swap};
      return r;
   endfunction

   // Magnitude ordering and alignment computed with integer arithmetic
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      res_t   r;
      int     ea, eb, el, es, d, sh;
      longint ma, mb, ml, ms, ext, p, q;
      bit     sw, st;
      ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
      eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
      ma = ((a[30:23] != 0) ? 64'd8388608 : 64'd0) + longint'(a[22:0]);
      mb = ((b[30:23] != 0) ? 64'd8388608 : 64'd0) + longint'(b[22:0]);
      sw = (eb > ea) || (eb == ea && mb > ma);
      el = sw ? eb : ea;  es = sw ? ea : eb;
      ml = sw ? mb : ma;  ms = sw ? ma : mb;
      d  = el - es;
      sh = (d > 27) ? 27 : d;
      ext = ms * 8;
      p   = longint'(1) << sh;
      q   = ext / p;
      st  = (ext % p) != 0;
      r.exp_large  = 8'(el);
      r.sig_large  = 27'(ml * 8);
      r.sig_small  = 27'(q) | 27'(st);
      r.sign_large = sw ? (b[31] ^ s) : a[31];
      r.eff_sub    = a[31] ^ b[31] ^ s;
      r.swap       = sw;
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Offers one pair and holds it until accepted; expectation is queued on transfer
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit use_lit, input res_t lit);
      int  n;
      bit  acc;
      n = 0;
      acc = 1'b0;
      in_valid = 1'b1; op_a = a; op_b = b; sub = s;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready && !flush;
         if (acc) begin
            sb.push_back(use_lit ? lit : model(a, b, s));
            n_acc++;
         end
         @(posedge clk); #1;
         n++;
      end
      if (!acc) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", 128'(sb.size()), 0);
   endtask

   always begin
      @(posedge clk); #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: pops on every output transfer, checks stall stability, tracks flush
   res_t prev_out;
   bit   prev_stall = 1'b0;
   always begin
      res_t e;
      @(negedge clk); #1;
      if (prev_stall && out_valid && rst_n) chk("stall_stable", 128'(cur_out()), 128'(prev_out));
      prev_out   = cur_out();
      prev_stall = out_valid && !out_ready && !flush && rst_n;
      if (out_valid && out_ready && rst_n) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("result", 128'(cur_out()), 128'(e));
         end
      end
      if (flush) sb.delete();
   end

   initial begin
      logic [31:0] a, b, r;
      int          eb;
      res_t        lit;

      #12;
      chk("rst_out_valid", 128'(out_valid), 0);
      chk("rst_in_ready", 128'(in_ready), 1);
      chk("rst_data", 128'(cur_out()), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors with hand-derived results
      lit = '{8'h7F, 27'h4000000, 27'h2000000, 1'b0, 1'b0, 1'b0};
      send(32'h3F800000, 32'h3F000000, 1'b0, 1, lit);
      lit = '{8'h7F, 27'h4000000, 27'h2000000, 1'b0, 1'b0, 1'b1};
      send(32'h3F000000, 32'hBF800000, 1'b1, 1, lit);
      lit = '{8'h7F, 27'h4000000, 27'h0000005, 1'b0, 1'b0, 1'b0};
      send(32'h3F800000, 32'h33800001, 1'b0, 1, lit);
      lit = '{8'h7F, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0};
      send(32'h3F800000, 32'h00000001, 1'b0, 1, lit);
      lit = '{8'h7F, 27'h6000000, 27'h4000000, 1'b1, 1'b1, 1'b1};
      send(32'h3F800000, 32'hBFC00000, 1'b0, 1, lit);
      lit = '{8'h80, 27'h6487ED8, 27'h6487ED8, 1'b0, 1'b0, 1'b0};
      send(32'h40490FDB, 32'h40490FDB, 1'b0, 1, lit);
      drain();

      // Backpressure: 4 back-to-back pairs into a stalled pipeline
      out_ready = 1'b0;
      n_acc = 0;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               r = $urandom; a = r; r = $urandom; b = r;
               send(a, b, 1'(i), 0, '0);
            end
         end
         begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
            chk("bp_out_valid", 128'(out_valid), 1);
            repeat (3) begin
               chk("bp_in_ready_low", 128'(in_ready), 0);
               chk("bp_two_accepts", 128'(n_acc), 2);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Flush with both stages occupied
      out_ready = 1'b0;
      send(32'h40000000, 32'h3F800000, 1'b0, 0, '0);
      send(32'h41000000, 32'h3F800000, 1'b1, 0, '0);
      chk("fl_full", 128'(out_valid), 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("fl_out_valid", 128'(out_valid), 0);
      chk("fl_in_ready", 128'(in_ready), 1);
      out_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("fl_no_ghost", 128'(out_valid), 0);

      // Randomized traffic with random backpressure and bubbles
      rand_bp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         r = $urandom; a = r;
         r = $urandom; b = r;
         case ($urandom_range(0, 4))
            0: begin
               eb = int'(a[30:23]) + $urandom_range(0, 40) - 20;
               if (eb < 0) eb = 0;
               if (eb > 254) eb = 254;
               b[30:23] = 8'(eb);
            end
            1: b[30:23] = a[30:23];
            2: b[30:23] = 8'd0;
            3: b = a;
            default: ;
         endcase
         if ($urandom_range(0, 1) != 0) send(a, b, 1'($urandom), 0, '0);
         else send(b, a, 1'($urandom), 0, '0);
         if ($urandom_range(0, 5) == 0) begin @(posedge clk); #1; end
      end
      rand_bp = 1'b0;
      out_ready = 1'b1;
      drain();

      // Asynchronous reset with pairs in flight
      send(32'h3F800000, 32'h3F000000, 1'b0, 0, '0);
      send(32'h40000000, 32'h3F000000, 1'b0, 0, '0);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 128'(out_valid), 0);
      chk("ar_in_ready", 128'(in_ready), 1);
      chk("ar_data", 128'(cur_out()), 0);
      sb.delete();
      @(negedge clk); rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         chk("ar_no_out", 128'(out_valid), 0);
      end
      lit = '{8'h7F, 27'h4000000, 27'h2000000, 1'b0, 1'b0, 1'b0};
      send(32'h3F800000, 32'h3F000000, 1'b0, 1, lit);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
